// File: rtl/inc_share_arbiter_pkg.sv
// Shared definitions for the increment-share arbiter family: FSM state
// encoding, default widths and the round-robin pick function.
package inc_share_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam int LP_NUM_REQ_DEF = 4;
    localparam int LP_DATA_W_DEF  = 8;
    localparam int LP_DP_LAT_DEF  = 1;
    localparam int LP_MAX_REQ     = 8;

    // First set bit of vld at or after ptr, wrapping modulo num; 0 when none is set.
    function automatic int rr_pick(input logic [LP_MAX_REQ-1:0] vld, input int ptr, input int num);
        int  idx;
        int  k;
        bit  found;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < LP_MAX_REQ; i++) begin
            k = ptr + i;
            if (k >= num) begin
                k = k - num;
            end else begin
                k = k;
            end
            if (!found && (i < num) && vld[k[2:0]]) begin
                idx   = k;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/inc_arb_rr_pick.sv
// Combinational round-robin picker with a priority mask: masked requesters
// win outright (lowest index first), the others rotate from the pointer.
module inc_arb_rr_pick
    import inc_share_arbiter_pkg::*;
#(
    parameter int P_N = LP_NUM_REQ_DEF
) (
    input  logic [P_N-1:0]         i_valid,
    input  logic [P_N-1:0]         i_mask,
    input  logic [$clog2(P_N)-1:0] i_ptr,
    output logic [$clog2(P_N)-1:0] o_idx,
    output logic                   o_any
);

    localparam int LP_IW = $clog2(P_N);

    logic [LP_MAX_REQ-1:0] w_prio;
    logic [LP_MAX_REQ-1:0] w_rest;
    int                    w_pick;

    // Select the priority group when it has any request, else rotate over the rest.
    always_comb begin
        w_prio = LP_MAX_REQ'(i_valid & i_mask);
        w_rest = LP_MAX_REQ'(i_valid & ~i_mask);
        if (w_prio != {LP_MAX_REQ{1'b0}}) begin
            w_pick = rr_pick(w_prio, 0, P_N);
        end else begin
            w_pick = rr_pick(w_rest, int'(i_ptr), P_N);
        end
        o_idx = LP_IW'(w_pick);
        o_any = (i_valid != {P_N{1'b0}});
    end

endmodule

// File: rtl/inc_share_arbiter.sv
// Shares one external registered increment datapath between P_NUM_REQ requesters.
// Build option INC_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module inc_share_arbiter
    import inc_share_arbiter_pkg::*;
#(
    parameter int P_NUM_REQ = LP_NUM_REQ_DEF,
    parameter int P_DATA_W  = LP_DATA_W_DEF,
    parameter int P_DP_LAT  = LP_DP_LAT_DEF
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic [P_NUM_REQ-1:0]          REQ_VALID_I,
    input  logic [P_NUM_REQ*P_DATA_W-1:0] REQ_DATA_I,
    output logic [P_NUM_REQ-1:0]          REQ_READY_O,
    output logic [P_NUM_REQ-1:0]          RSP_VALID_O,
    output logic [P_DATA_W-1:0]           RSP_DATA_O,
    output logic                          RSP_OVF_O,
    input  logic [P_NUM_REQ-1:0]          RSP_READY_I,
    output logic                          DP_VALID_O,
    output logic [P_DATA_W-1:0]           DP_DATA_O,
    input  logic [P_DATA_W-1:0]           DP_DATA_I,
    output logic                          BUSY_O
);

    localparam int         LP_IW       = $clog2(P_NUM_REQ);
    localparam logic [1:0] LP_CNT_INIT = 2'(P_DP_LAT - 1);

    arb_state_t             r_state;
    logic [LP_IW-1:0]       r_grant;
    logic [LP_IW-1:0]       r_ptr;
    logic [1:0]             r_cnt;
    logic [P_DATA_W-1:0]    r_op;
    logic [P_DATA_W-1:0]    r_rsp_data;
    logic                   r_rsp_ovf;

    logic [P_NUM_REQ-1:0]   w_mask;
    logic [P_NUM_REQ-1:0]   w_grant_oh;
    logic [LP_IW-1:0]       w_pick_idx;
    logic [LP_IW-1:0]       w_ptr_next;
    logic                   w_pick_any;
    logic [P_DATA_W-1:0]    w_req_data;
    logic                   w_rsp_hs;

`ifdef INC_ARB_PRIO0_EN
    assign w_mask = {{(P_NUM_REQ-1){1'b0}}, 1'b1};
`else
    assign w_mask = {P_NUM_REQ{1'b0}};
`endif

    inc_arb_rr_pick #(
        .P_N (P_NUM_REQ)
    ) u_pick (
        .i_valid (REQ_VALID_I),
        .i_mask  (w_mask),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Grant decode, granted operand select and pointer successor.
    always_comb begin
        w_grant_oh          = {P_NUM_REQ{1'b0}};
        w_grant_oh[r_grant] = 1'b1;
        w_req_data          = REQ_DATA_I[int'(r_grant)*P_DATA_W +: P_DATA_W];
        if (r_grant == LP_IW'(P_NUM_REQ - 1)) begin
            w_ptr_next = {LP_IW{1'b0}};
        end else begin
            w_ptr_next = r_grant + LP_IW'(1);
        end
    end

    assign w_rsp_hs    = (r_state == S_RESP) && RSP_READY_I[r_grant];
    assign REQ_READY_O = (r_state == S_ISSUE) ? w_grant_oh : {P_NUM_REQ{1'b0}};
    assign DP_VALID_O  = (r_state == S_ISSUE);
    assign DP_DATA_O   = (r_state == S_ISSUE) ? w_req_data : {P_DATA_W{1'b0}};
    assign RSP_VALID_O = (r_state == S_RESP) ? w_grant_oh : {P_NUM_REQ{1'b0}};
    assign RSP_DATA_O  = r_rsp_data;
    assign RSP_OVF_O   = r_rsp_ovf;
    assign BUSY_O      = (r_state != S_IDLE);

    // Operation sequencer: arbitrate, issue, wait out the datapath, hold the response.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= S_IDLE;
            r_grant    <= {LP_IW{1'b0}};
            r_ptr      <= {LP_IW{1'b0}};
            r_cnt      <= 2'd0;
            r_op       <= {P_DATA_W{1'b0}};
            r_rsp_data <= {P_DATA_W{1'b0}};
            r_rsp_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_op    <= w_req_data;
                    // A strict-priority win leaves the rotation where it was.
                    r_ptr   <= w_mask[r_grant] ? r_ptr : w_ptr_next;
                    r_cnt   <= LP_CNT_INIT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rsp_data <= DP_DATA_I;
                        r_rsp_ovf  <= (r_op == {P_DATA_W{1'b1}});
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs && w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= S_ISSUE;
                    end else if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inc_share_arbiter.sv
// Self-checking bench for inc_share_arbiter: vector table plus a response
// scoreboard fed from an independent round-robin reference.
module tb_inc_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 1;

    logic             CLK_I = 1'b0;
    logic             RST_I;
    logic [N-1:0]     REQ_VALID_I;
    logic [N*W-1:0]   REQ_DATA_I;
    logic [N-1:0]     REQ_READY_O;
    logic [N-1:0]     RSP_VALID_O;
    logic [W-1:0]     RSP_DATA_O;
    logic             RSP_OVF_O;
    logic [N-1:0]     RSP_READY_I;
    logic             DP_VALID_O;
    logic [W-1:0]     DP_DATA_O;
    logic [W-1:0]     DP_DATA_I;
    logic             BUSY_O;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [N-1:0] onehot;
        logic [W-1:0] data;
        logic         ovf;
    } rsp_t;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        int             grant;
        logic [W-1:0]   rsp;
        logic           ovf;
    } vec_t;

    rsp_t         exp_q[$];
    int           grant_log[$];
    int           rsp_cycle_log[$];
    int           ref_ptr = 0;
    int           cyc = 0;
    logic [N-1:0] v_at_edge = '0;
    logic [W-1:0] dp_pipe [LAT];

    always #5 CLK_I = ~CLK_I;

    inc_share_arbiter #(
        .P_NUM_REQ (N),
        .P_DATA_W  (W),
        .P_DP_LAT  (LAT)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .REQ_VALID_I (REQ_VALID_I),
        .REQ_DATA_I  (REQ_DATA_I),
        .REQ_READY_O (REQ_READY_O),
        .RSP_VALID_O (RSP_VALID_O),
        .RSP_DATA_O  (RSP_DATA_O),
        .RSP_OVF_O   (RSP_OVF_O),
        .RSP_READY_I (RSP_READY_I),
        .DP_VALID_O  (DP_VALID_O),
        .DP_DATA_O   (DP_DATA_O),
        .DP_DATA_I   (DP_DATA_I),
        .BUSY_O      (BUSY_O)
    );

    // External increment datapath with LAT register stages.
    always @(posedge CLK_I) begin
        dp_pipe[0] <= DP_DATA_O + 8'd1;
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign DP_DATA_I = dp_pipe[LAT-1];

    always @(posedge CLK_I) begin
        cyc       <= cyc + 1;
        v_at_edge <= REQ_VALID_I;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0 && g < N) r[g] = 1'b1;
        return r;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef INC_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic monitor_step();
        int           g;
        logic [W-1:0] d;
        rsp_t         e;
        if (RST_I) begin
            ref_ptr = 0;
            exp_q.delete();
            return;
        end
        if (REQ_READY_O != '0) begin
            g = model_pick(v_at_edge, ref_ptr);
            check("sb_grant", 32'(REQ_READY_O), 32'(onehot(g)));
            check("sb_dp_valid", 32'(DP_VALID_O), 32'd1);
            if (g >= 0) begin
                d = REQ_DATA_I[g*W +: W];
                check("sb_dp_data", 32'(DP_DATA_O), 32'(d));
                e.onehot = onehot(g);
                e.data   = d + 8'd1;
                e.ovf    = (d == 8'hFF);
                exp_q.push_back(e);
                grant_log.push_back(g);
`ifdef INC_ARB_PRIO0_EN
                if (g != 0) ref_ptr = (g + 1) % N;
`else
                ref_ptr = (g + 1) % N;
`endif
            end
        end
        if ((RSP_VALID_O & RSP_READY_I) != '0) begin
            rsp_cycle_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 32'(RSP_VALID_O), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp_valid", 32'(RSP_VALID_O), 32'(e.onehot));
                check("sb_rsp_data", 32'(RSP_DATA_O), 32'(e.data));
                check("sb_rsp_ovf", 32'(RSP_OVF_O), 32'(e.ovf));
            end
        end
    endtask

    always @(negedge CLK_I) monitor_step();

    task automatic wait_grant();
        int k;
        k = 0;
        @(negedge CLK_I);
        while (REQ_READY_O == '0 && k < 20) begin
            @(negedge CLK_I);
            k++;
        end
        check("grant_seen", 32'(REQ_READY_O != '0), 32'd1);
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        @(negedge CLK_I);
        while (RSP_VALID_O == '0 && k < 20) begin
            @(negedge CLK_I);
            k++;
        end
        check("rsp_seen", 32'(RSP_VALID_O != '0), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
            @(posedge CLK_I);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(REQ_READY_O), 32'd0);
        check({tag, "_rsp_valid"}, 32'(RSP_VALID_O), 32'd0);
        check({tag, "_rsp_data"},  32'(RSP_DATA_O),  32'd0);
        check({tag, "_rsp_ovf"},   32'(RSP_OVF_O),   32'd0);
        check({tag, "_dp_valid"},  32'(DP_VALID_O),  32'd0);
        check({tag, "_dp_data"},   32'(DP_DATA_O),   32'd0);
        check({tag, "_busy"},      32'(BUSY_O),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   c0;
        int   base_g;
        int   base_r;
        int   exp_fair[5];
        int   exp_pair[4];

        vecs[0] = '{4'b0001, 32'h0000_0041, 0, 8'h42, 1'b0};
        vecs[1] = '{4'b0100, 32'h00FF_0000, 2, 8'h00, 1'b1};
        vecs[2] = '{4'b0011, 32'h0000_2010, 0, 8'h11, 1'b0};
        vecs[3] = '{4'b1000, 32'h7F00_0000, 3, 8'h80, 1'b0};
        vecs[4] = '{4'b0110, 32'h00FE_AA00, 1, 8'hAB, 1'b0};
        vecs[5] = '{4'b0110, 32'h00FE_AA00, 2, 8'hFF, 1'b0};
        vecs[6] = '{4'b1110, 32'hFF06_0500, 3, 8'h00, 1'b1};
        vecs[7] = '{4'b0010, 32'h0000_0000, 1, 8'h01, 1'b0};
`ifdef INC_ARB_PRIO0_EN
        exp_fair = '{0, 0, 0, 0, 0};
        exp_pair = '{0, 0, 0, 0};
`else
        exp_fair = '{0, 1, 2, 3, 0};
        exp_pair = '{0, 1, 0, 1};
`endif

        RST_I       = 1'b1;
        REQ_VALID_I = '0;
        REQ_DATA_I  = '0;
        RSP_READY_I = 4'hF;
        repeat (3) @(posedge CLK_I);
        #1;
        check_all_zero("reset");
        RST_I = 1'b0;

        // Single operations from idle, walking the rotation pointer.
        for (int v = 0; v < 8; v++) begin
            @(posedge CLK_I); #1;
            REQ_DATA_I  = vecs[v].data;
            REQ_VALID_I = vecs[v].valid;
            c0          = cyc;
            wait_grant();
            check($sformatf("vec%0d_grant", v), 32'(REQ_READY_O), 32'(onehot(vecs[v].grant)));
            @(posedge CLK_I); #1;
            REQ_VALID_I = '0;
            wait_rsp();
            check($sformatf("vec%0d_rsp_valid", v), 32'(RSP_VALID_O), 32'(onehot(vecs[v].grant)));
            check($sformatf("vec%0d_rsp_data", v), 32'(RSP_DATA_O), 32'(vecs[v].rsp));
            check($sformatf("vec%0d_rsp_ovf", v), 32'(RSP_OVF_O), 32'(vecs[v].ovf));
            check($sformatf("vec%0d_latency", v), 32'(cyc - c0), 32'd3);
        end

        // All four requesting continuously.
        pulse_reset();
        base_g      = grant_log.size();
        base_r      = rsp_cycle_log.size();
        REQ_DATA_I  = 32'h4030_2010;
        REQ_VALID_I = 4'hF;
        for (int k = 0; k < 60 && grant_log.size() < base_g + 5; k++) begin
            @(posedge CLK_I); #1;
        end
        REQ_VALID_I = '0;
        drain();
        check("fair_count", 32'(grant_log.size() - base_g), 32'd5);
        if (grant_log.size() >= base_g + 5 && rsp_cycle_log.size() >= base_r + 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("fair_order%0d", i), 32'(grant_log[base_g+i]), 32'(exp_fair[i]));
            for (int i = 1; i < 5; i++)
                check($sformatf("fair_spacing%0d", i),
                      32'(rsp_cycle_log[base_r+i] - rsp_cycle_log[base_r+i-1]), 32'd3);
        end

        // Requesters 0 and 1 continuously.
        pulse_reset();
        base_g      = grant_log.size();
        REQ_DATA_I  = 32'h0000_2010;
        REQ_VALID_I = 4'b0011;
        for (int k = 0; k < 60 && grant_log.size() < base_g + 4; k++) begin
            @(posedge CLK_I); #1;
        end
        REQ_VALID_I = '0;
        drain();
        check("pair_count", 32'(grant_log.size() - base_g), 32'd4);
        if (grant_log.size() >= base_g + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("pair_order%0d", i), 32'(grant_log[base_g+i]), 32'(exp_pair[i]));
        end

        // Response backpressure on requester 1.
        @(posedge CLK_I); #1;
        RSP_READY_I = 4'b1101;
        REQ_DATA_I  = 32'h0000_5500;
        REQ_VALID_I = 4'b0010;
        wait_grant();
        check("bp_grant", 32'(REQ_READY_O), 32'h2);
        @(posedge CLK_I); #1;
        REQ_VALID_I = '0;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(RSP_VALID_O), 32'h2);
            check($sformatf("bp_data%0d", i), 32'(RSP_DATA_O), 32'h56);
            check($sformatf("bp_busy%0d", i), 32'(BUSY_O), 32'd1);
            check($sformatf("bp_no_issue%0d", i), 32'(DP_VALID_O), 32'd0);
            check($sformatf("bp_no_accept%0d", i), 32'(REQ_READY_O), 32'd0);
            @(posedge CLK_I); #1;
            if (i == 0) begin
                REQ_DATA_I  = 32'h0000_5507;
                REQ_VALID_I = 4'b0001;
            end
            @(negedge CLK_I);
        end
        @(posedge CLK_I); #1;
        RSP_READY_I = 4'hF;
        @(negedge CLK_I);
        check("bp_release_valid", 32'(RSP_VALID_O), 32'h2);
        @(negedge CLK_I);
        check("bp_next_accept", 32'(REQ_READY_O), 32'h1);
        check("bp_rsp_done", 32'(RSP_VALID_O), 32'd0);
        @(posedge CLK_I); #1;
        REQ_VALID_I = '0;
        drain();

        // Reset while an operation waits on the datapath.
        @(posedge CLK_I); #1;
        REQ_DATA_I  = 32'h0010_0000;
        REQ_VALID_I = 4'b0100;
        wait_grant();
        @(posedge CLK_I); #1;
        REQ_VALID_I = '0;
        check("mid_busy", 32'(BUSY_O), 32'd1);
        RST_I = 1'b1;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        repeat (3) @(negedge CLK_I);
        check("mid_no_stale_rsp", 32'(RSP_VALID_O), 32'd0);
        check("mid_idle", 32'(BUSY_O), 32'd0);
        @(posedge CLK_I); #1;
        REQ_DATA_I  = 32'h9900_2100;
        REQ_VALID_I = 4'b1010;
        wait_grant();
        check("mid_ptr_cleared", 32'(REQ_READY_O), 32'h2);
        @(posedge CLK_I); #1;
        REQ_VALID_I = '0;
        drain();
        @(posedge CLK_I); #1;
        REQ_VALID_I = 4'b1000;
        wait_grant();
        check("mid_grant3", 32'(REQ_READY_O), 32'h8);
        @(posedge CLK_I); #1;
        REQ_VALID_I = '0;
        drain();

        repeat (3) @(posedge CLK_I);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
